// File: rtl/activation_pipe.sv
// activation_pipe: LUT-based sigmoid/tanh/ReLU/bypass unit; `define ACTIVATION_INTERP_EN adds linear interpolation.
// Latency: 3 register stages, accept-to-out_valid 3 cycles, 1 sample/cycle, order preserved.
// Backpressure: global stall, in_ready = !out_valid || out_ready; every stage holds while stalled.
module activation_pipe #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int LUT_ADDR_W = 7,
    parameter int SAT_LOG2   = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  sat_cnt
);
    localparam int S     = FRAC_W + SAT_LOG2 - LUT_ADDR_W;
    localparam int LUT_N = 1 << LUT_ADDR_W;
    localparam int MAG_W = DATA_W + 2;
    localparam logic [MAG_W-1:0]  SAT_TH = MAG_W'(1) << (FRAC_W + SAT_LOG2);
    localparam logic [DATA_W-1:0] ONE    = DATA_W'(1) << FRAC_W;
    localparam logic [1:0] MODE_SIG  = 2'b00;
    localparam logic [1:0] MODE_TANH = 2'b01;
    localparam logic [1:0] MODE_RELU = 2'b10;

    // Elaboration-time sigmoid: e^x by Taylor series in 64-fraction-bit fixed point,
    // x = i / 2^(LUT_ADDR_W-SAT_LOG2), then round(2^FRAC_W * e^x / (e^x + 1)).
    function automatic logic [DATA_W-1:0] sig_entry(input int i);
        logic [127:0] one, term, e, den, num;
        one  = 128'd1 << 64;
        term = one;
        e    = one;
        for (int n = 1; n < 80; n++) begin
            term = (term * 128'(i)) / (128'(n) << (LUT_ADDR_W - SAT_LOG2));
            e    = e + term;
        end
        den = e + one;
        num = (e << (FRAC_W + 1)) + den;
        return DATA_W'(num / (den << 1));
    endfunction

    logic [DATA_W-1:0] lut [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam logic [DATA_W-1:0] ENTRY = sig_entry(g);
        assign lut[g] = ENTRY;
    end

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1 (condition): magnitude is kept two bits wider so |0x8000| and 2|x| never overflow.
    logic                  in_neg, sat_in;
    logic [MAG_W-1:0]      x_ext, abs_in, mag_in;
    logic [LUT_ADDR_W-1:0] idx_in;
    assign in_neg = in_data[DATA_W-1];
    assign x_ext  = {{2{in_data[DATA_W-1]}}, in_data};
    assign abs_in = in_neg ? (~x_ext + 1'b1) : x_ext;
    assign mag_in = (in_mode == MODE_TANH) ? (abs_in << 1) : abs_in;
    assign sat_in = (mag_in >= SAT_TH);
    assign idx_in = LUT_ADDR_W'(mag_in >> S);

    logic                  vld1, neg1, sat1;
    logic [1:0]            mode1;
    logic [LUT_ADDR_W-1:0] idx1;
    logic [DATA_W-1:0]     x1;
    logic                  vld2, neg2, sat2;
    logic [1:0]            mode2;
    logic [DATA_W-1:0]     x2, lo2;

`ifdef ACTIVATION_INTERP_EN
    localparam int FW = (S > 0) ? S : 1;
    localparam int EW = DATA_W + S;
    logic [FW-1:0]     frac_in, frac1, frac2;
    logic [DATA_W-1:0] hi1, hi2;
    assign frac_in = (S > 0) ? mag_in[FW-1:0] : '0;
    assign hi1     = (idx1 == LUT_ADDR_W'(LUT_N - 1)) ? ONE : lut[LUT_ADDR_W'(idx1 + 1'b1)];
`endif

    // Stage 3 (finish)
    logic [DATA_W-1:0] s_val, sig_val, result;
`ifdef ACTIVATION_INTERP_EN
    logic signed [EW-1:0] diff, prod, interp;
    always_comb begin
        diff   = $signed(EW'(hi2)) - $signed(EW'(lo2));
        prod   = diff * $signed(EW'(frac2));
        interp = $signed(EW'(lo2)) + (prod >>> S);
        s_val  = sat2 ? ONE : DATA_W'(interp);
    end
`else
    assign s_val = sat2 ? ONE : lo2;
`endif

    always_comb begin
        sig_val = neg2 ? (ONE - s_val) : s_val;
        result  = x2;
        case (mode2)
            MODE_SIG:  result = sig_val;
            MODE_TANH: result = (sig_val << 1) - ONE;
            MODE_RELU: result = neg2 ? '0 : x2;
            default:   result = x2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1      <= 1'b0;
            neg1      <= 1'b0;
            sat1      <= 1'b0;
            mode1     <= '0;
            idx1      <= '0;
            x1        <= '0;
            vld2      <= 1'b0;
            neg2      <= 1'b0;
            sat2      <= 1'b0;
            mode2     <= '0;
            x2        <= '0;
            lo2       <= '0;
`ifdef ACTIVATION_INTERP_EN
            frac1     <= '0;
            frac2     <= '0;
            hi2       <= '0;
`endif
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_cnt   <= '0;
        end else begin
            if (advance) begin
                vld1 <= in_valid;
                if (in_valid) begin
                    neg1  <= in_neg;
                    sat1  <= sat_in;
                    mode1 <= in_mode;
                    idx1  <= idx_in;
                    x1    <= in_data;
`ifdef ACTIVATION_INTERP_EN
                    frac1 <= frac_in;
`endif
                end
                vld2 <= vld1;
                if (vld1) begin
                    neg2  <= neg1;
                    sat2  <= sat1;
                    mode2 <= mode1;
                    x2    <= x1;
                    lo2   <= lut[idx1];
`ifdef ACTIVATION_INTERP_EN
                    frac2 <= frac1;
                    hi2   <= hi1;
`endif
                end
                out_valid <= vld2;
                if (vld2) begin
                    out_data <= result;
                end
            end
            if (in_valid && advance && !in_mode[1] && sat_in && !(&sat_cnt)) begin
                sat_cnt <= sat_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/activation_pipe.md
Name: activation_pipe

Overview:
- Pipelined, parametrised fixed-point activation unit for the neuron datapath.
- Successor to the single-function combinational sigmoid. Adds:
  - a per-sample mode: sigmoid, tanh, ReLU or bypass;
  - generic Q-format width;
  - a configurable LUT depth;
  - a valid/ready streaming interface with back-pressure;
  - a saturation event counter.
- Sits between the MAC accumulator output and the layer writeback buffer.

Parameters:
- DATA_W, 16: total signed two's-complement width of input and output.
- FRAC_W, 8: fractional bits (1.0 = 1<<FRAC_W).
- LUT_ADDR_W, 7: LUT holds 2^LUT_ADDR_W sigmoid samples, uniformly spanning [0, 2^SAT_LOG2).
- SAT_LOG2, 3: sigmoid saturation magnitude is 2^SAT_LOG2 (8.0). Constraint: FRAC_W+SAT_LOG2 >= LUT_ADDR_W.
- CNT_W, 16: width of the saturation counter.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: block can accept a sample this cycle.
- in_data, in, DATA_W: signed Q(DATA_W-FRAC_W).FRAC_W operand.
- in_mode, in, 2: 00 sigmoid, 01 tanh, 10 ReLU, 11 bypass. Sampled together with in_data.
- out_valid, out, 1: output sample valid.
- out_ready, in, 1: downstream accepts the output.
- out_data, out, DATA_W: result in the same Q format.
- sat_cnt, out, CNT_W: count of saturated sigmoid/tanh samples. Saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst_n low): all stage valids = 0, out_valid = 0, out_data = 0, sat_cnt = 0, in_ready = 1 once rst_n is high. Reset mid-stream discards all in-flight samples; nothing is emitted afterwards.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - While stalled, all stage registers hold and out_data is stable.
- Throughput and latency: 1 sample/cycle; latency 3 cycles accept-to-out_valid with no stall. Order is preserved.
- Stage 1 (condition):
  - mag = |x|. For tanh, x is first doubled: tanh(x) = 2*sig(2x) - 1.
  - The most negative input (0x8000) is treated as a saturating magnitude; it must not overflow.
  - sat = 1 when the magnitude (doubled for tanh) >= 2^SAT_LOG2 << FRAC_W, or when doubling overflows.
  - idx = mag >> S, where S = FRAC_W+SAT_LOG2-LUT_ADDR_W (4 at defaults); frac = mag[S-1:0].
- Stage 2 (LUT):
  - Read lo = LUT[idx] and hi = LUT[idx+1].
  - At idx = max, hi is the constant 1.0.
  - Entry i = round(sigmoid(i * 2^(SAT_LOG2-LUT_ADDR_W)) * 2^FRAC_W). The ROM content is generated in-block from the parameters.
- Stage 3 (finish):
  - Sigmoid magnitude s = lo, or the interpolated value (see Optional Feature).
  - Sat: s = 1.0.
  - Sigmoid result: x >= 0 -> s; x < 0 -> 1.0 - s.
  - Tanh result: 2*sig - 1.0, signed, in the range [-1.0, +1.0].
  - ReLU: x < 0 -> 0, else x.
  - Bypass: x unchanged.
- sat_cnt increments by 1 on each accepted input whose mode is sigmoid or tanh and whose sat flag = 1. It holds at 2^CNT_W-1.
- Out-of-range inputs saturate cleanly:
  - sigmoid x >= 8.0 -> 0x0100; sigmoid x <= -8.0 -> 0x0000;
  - tanh |x| >= 4.0 -> ±0x0100.
- Simultaneous out_ready and in_valid while full: output and input transfer in the same cycle, no bubble.

Optional Feature:
- Macro: ACTIVATION_INTERP_EN.
- Defined: s = lo + (((hi - lo) * frac) >> S), computed with signed intermediates of width DATA_W+S.
- Undefined: s = lo (frac ignored). The hi read and multiplier are removed; latency is unchanged (3).

Test Plan:
- Sigmoid, in_data = 0x0000, 0x0100, 0xFF00 -> out_data = 0x0080, 0x00BB, 0x0045, each 3 cycles after accept, back-to-back.
- Saturation: sigmoid 0x0900 -> 0x0100; sigmoid 0xF700 -> 0x0000; tanh 0x0500 -> 0x0100; sigmoid 0x8000 -> 0x0000. Afterwards sat_cnt = 4.
- Modes: ReLU 0xFE00 -> 0x0000; ReLU 0x0380 -> 0x0380; bypass 0xABCD -> 0xABCD; tanh 0x0000 -> 0x0000. sat_cnt is unchanged.
- Back-pressure: stream 6 samples while out_ready is held low for 5 cycles.
  - in_ready falls after 3 accepts.
  - out_data is held stable.
  - All 6 outputs arrive in order with no loss or duplication.
- Interpolation (macro defined): sigmoid 0x0108 lands between entries 16 and 17 -> 0x00BB + (((LUT[17] - LUT[16]) * 8) >> 4). Without the macro -> 0x00BB.
- Reset: assert rst_n low with 3 samples in flight -> out_valid = 0 and sat_cnt = 0 immediately. No stale outputs after release; the next sample has latency 3.
